// File: rtl/ram_port_arb_if.sv
// Requester-side bus of the SRAM port arbiter: three requesters packed
// side by side (requester i occupies slice i of every vector field).
interface ram_port_arb_if;
    logic [2:0]  m_req;
    logic [2:0]  m_we;
    logic [11:0] m_be;
    logic [95:0] m_addr;
    logic [95:0] m_wdata;
    logic [2:0]  m_gnt;
    logic [2:0]  m_rvalid;
    logic [2:0]  m_err;
    logic [31:0] m_rdata;

    modport master (
        output m_req, m_we, m_be, m_addr, m_wdata,
        input  m_gnt, m_rvalid, m_err, m_rdata
    );

    modport slave (
        input  m_req, m_we, m_be, m_addr, m_wdata,
        output m_gnt, m_rvalid, m_err, m_rdata
    );
endinterface

// File: rtl/ram_port_arb.sv
// Shares one SRAM port between boot loader (0), CPU ifetch (1) and CPU
// data (2), and holds the CPU in reset until the boot loader is done.
// Optional macro RAM_ARB_RR_EN: round-robin between requesters 1 and 2;
// without it requester 2 always wins over requester 1.
//
// state | meaning
// BOOT  | boot loader owns the RAM, CPU held in reset
// RUN   | CPU owns the RAM, boot loader accesses are errored
module ram_port_arb #(
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           boot_done,
    output logic           cpu_rst,
    ram_port_arb_if.slave  m,
    output logic           ram_req,
    output logic           ram_we,
    output logic [3:0]     ram_be,
    output logic [AW-1:0]  ram_addr,
    output logic [31:0]    ram_wdata,
    input  logic [31:0]    ram_rdata
);

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    state_t      state_q;
    logic        cpu_rst_q;
    logic        prefer_2;
    logic        win_vld;
    logic [1:0]  win_idx;
    logic        win_we;
    logic [3:0]  win_be;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic        in_range;
    logic        acc_err;
    logic        rsp_valid_q;
    logic [1:0]  rsp_idx_q;
    logic        rsp_err_q;
    logic        unused_addr_lsb;

`ifdef RAM_ARB_RR_EN
    logic rr_q;  // 0: requester 1 preferred, 1: requester 2 preferred

    // Round-robin pointer flips to the loser after each CPU-side grant
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else if (win_vld && win_idx == 2'd1) begin
            rr_q <= 1'b1;
        end else if (win_vld && win_idx == 2'd2) begin
            rr_q <= 1'b0;
        end
    end

    assign prefer_2 = rr_q;
`else
    assign prefer_2 = 1'b1;
`endif

    // Pick the winner; the boot loader only gets the port in RUN when the CPU is idle
    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        if (state_q == BOOT) begin
            win_vld = m.m_req[0];
        end else if (m.m_req[1] && m.m_req[2]) begin
            win_vld = 1'b1;
            win_idx = prefer_2 ? 2'd2 : 2'd1;
        end else if (m.m_req[2]) begin
            win_vld = 1'b1;
            win_idx = 2'd2;
        end else if (m.m_req[1]) begin
            win_vld = 1'b1;
            win_idx = 2'd1;
        end else if (m.m_req[0]) begin
            win_vld = 1'b1;
        end
    end

    // Mux the winner's request fields
    always_comb begin
        win_we    = m.m_we[0];
        win_be    = m.m_be[3:0];
        win_addr  = m.m_addr[31:0];
        win_wdata = m.m_wdata[31:0];
        case (win_idx)
            2'd1: begin
                win_we    = m.m_we[1];
                win_be    = m.m_be[7:4];
                win_addr  = m.m_addr[63:32];
                win_wdata = m.m_wdata[63:32];
            end
            2'd2: begin
                win_we    = m.m_we[2];
                win_be    = m.m_be[11:8];
                win_addr  = m.m_addr[95:64];
                win_wdata = m.m_wdata[95:64];
            end
            default: ;
        endcase
    end

    // Byte offset within a word is irrelevant to a word-wide RAM
    assign unused_addr_lsb = ^win_addr[1:0];

    assign in_range = (win_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign acc_err  = !in_range || (state_q == RUN && win_idx == 2'd0);

    assign ram_req   = win_vld && !acc_err;
    assign ram_we    = ram_req && win_we;
    assign ram_be    = ram_req ? win_be : 4'h0;
    assign ram_addr  = ram_req ? win_addr[AW+1:2] : '0;
    assign ram_wdata = ram_req ? win_wdata : 32'h0;

    assign m.m_gnt = win_vld ? (3'b001 << win_idx) : 3'b000;

    // Boot/run sequencing with the CPU reset registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BOOT;
            cpu_rst_q <= 1'b1;
        end else begin
            case (state_q)
                BOOT: begin
                    if (boot_done) begin
                        state_q   <= RUN;
                        cpu_rst_q <= 1'b0;
                    end
                end
                RUN: begin
                    state_q   <= RUN;
                    cpu_rst_q <= 1'b0;
                end
                default: begin
                    state_q   <= BOOT;
                    cpu_rst_q <= 1'b1;
                end
            endcase
        end
    end

    assign cpu_rst = cpu_rst_q;

    // Remember who was granted so the RAM data returns to the right requester
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= 2'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= win_vld;
            rsp_idx_q   <= win_idx;
            rsp_err_q   <= win_vld && acc_err;
        end
    end

    assign m.m_rvalid = rsp_valid_q ? (3'b001 << rsp_idx_q) : 3'b000;
    assign m.m_err    = (rsp_valid_q && rsp_err_q) ? (3'b001 << rsp_idx_q) : 3'b000;
    assign m.m_rdata  = (rsp_valid_q && !rsp_err_q) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_ram_port_arb.sv
module tb_ram_port_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        boot_done;
    logic        cpu_rst;
    logic        ram_req;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    int n_chk  = 0;
    int n_fail = 0;

    ram_port_arb_if bus ();

    ram_port_arb dut (
        .clk       (clk),
        .rst       (rst),
        .boot_done (boot_done),
        .cpu_rst   (cpu_rst),
        .m         (bus.slave),
        .ram_req   (ram_req),
        .ram_we    (ram_we),
        .ram_be    (ram_be),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Small RAM model, one-cycle read latency, preloaded with A500_00ii
    logic [31:0] mem [16];
    logic        mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA500_0000 | i;
            mem_ready <= 1'b1;
        end else if (ram_req) begin
            for (int b = 0; b < 4; b++)
                if (ram_we && ram_be[b]) mem[ram_addr[3:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr[3:0]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] req, input logic [2:0] we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.m_req   = req;
        bus.m_we    = we;
        bus.m_be    = {3{be}};
        bus.m_addr  = {3{addr}};
        bus.m_wdata = {3{wdata}};
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        bd;
        logic [2:0]  e_gnt;
        logic        e_ram_req;
        logic [11:0] e_ram_addr;
        logic        e_cpu_rst;
        logic [2:0]  e_rv;
        logic [2:0]  e_err;
        logic        chk_rdata;
        logic [31:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(logic [2:0] req, logic [2:0] we, logic [3:0] be, logic [31:0] addr,
                                logic [31:0] wdata, logic bd, logic [2:0] e_gnt, logic e_ram_req,
                                logic [11:0] e_ram_addr, logic e_cpu_rst, logic [2:0] e_err,
                                logic chk_rdata, logic [31:0] e_rdata);
        vec_t v;
        v.req = req; v.we = we; v.be = be; v.addr = addr; v.wdata = wdata; v.bd = bd;
        v.e_gnt = e_gnt; v.e_ram_req = e_ram_req; v.e_ram_addr = e_ram_addr;
        v.e_cpu_rst = e_cpu_rst; v.e_rv = e_gnt; v.e_err = e_err;
        v.chk_rdata = chk_rdata; v.e_rdata = e_rdata;
        return v;
    endfunction

`ifdef RAM_ARB_RR_EN
    localparam logic [2:0] G5 = 3'b010, G6 = 3'b100, G7 = 3'b010, G8 = 3'b100;
`else
    localparam logic [2:0] G5 = 3'b100, G6 = 3'b100, G7 = 3'b100, G8 = 3'b100;
`endif

    vec_t vecs [14];
    vec_t pv;

    initial begin
        //            req     we      be    addr          wdata         bd  gnt     rreq ra     cpu  err     chk rdata
        vecs[0]  = mk(3'b001, 3'b001, 4'hF, 32'h10,       32'hDEADBEEF, 0, 3'b001, 1, 12'h4, 1, 3'b000, 0, 32'h0);
        vecs[1]  = mk(3'b001, 3'b000, 4'hF, 32'h10,       32'h0,        0, 3'b001, 1, 12'h4, 1, 3'b000, 1, 32'hDEADBEEF);
        vecs[2]  = mk(3'b001, 3'b000, 4'hF, 32'h10,       32'h0,        1, 3'b001, 1, 12'h4, 1, 3'b000, 1, 32'hDEADBEEF);
        vecs[3]  = mk(3'b000, 3'b000, 4'h0, 32'h0,        32'h0,        0, 3'b000, 0, 12'h0, 0, 3'b000, 1, 32'h0);
        vecs[4]  = mk(3'b001, 3'b000, 4'hF, 32'h10,       32'h0,        0, 3'b001, 0, 12'h0, 0, 3'b001, 1, 32'h0);
        vecs[5]  = mk(3'b110, 3'b000, 4'hF, 32'h20,       32'h0,        0, G5,     1, 12'h8, 0, 3'b000, 1, 32'hA500_0008);
        vecs[6]  = mk(3'b110, 3'b000, 4'hF, 32'h24,       32'h0,        0, G6,     1, 12'h9, 0, 3'b000, 1, 32'hA500_0009);
        vecs[7]  = mk(3'b110, 3'b000, 4'hF, 32'h28,       32'h0,        0, G7,     1, 12'hA, 0, 3'b000, 1, 32'hA500_000A);
        vecs[8]  = mk(3'b110, 3'b000, 4'hF, 32'h2C,       32'h0,        0, G8,     1, 12'hB, 0, 3'b000, 1, 32'hA500_000B);
        vecs[9]  = mk(3'b010, 3'b000, 4'hF, 32'h4000,     32'h0,        0, 3'b010, 0, 12'h0, 0, 3'b010, 1, 32'h0);
        vecs[10] = mk(3'b100, 3'b100, 4'h3, 32'h30,       32'h12345678, 0, 3'b100, 1, 12'hC, 0, 3'b000, 0, 32'h0);
        vecs[11] = mk(3'b010, 3'b000, 4'hF, 32'h30,       32'h0,        0, 3'b010, 1, 12'hC, 0, 3'b000, 1, 32'hA500_5678);
        vecs[12] = mk(3'b000, 3'b000, 4'h0, 32'h0,        32'h0,        1, 3'b000, 0, 12'h0, 0, 3'b000, 1, 32'h0);
        vecs[13] = mk(3'b000, 3'b000, 4'h0, 32'h0,        32'h0,        0, 3'b000, 0, 12'h0, 0, 3'b000, 1, 32'h0);

        rst = 1'b1;
        boot_done = 1'b0;
        drive(3'b000, 3'b000, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset cpu_rst", 32'(cpu_rst), 32'h1);
        chk("reset rvalid", 32'(bus.m_rvalid), 32'h0);
        chk("reset err", 32'(bus.m_err), 32'h0);
        chk("reset rdata", bus.m_rdata, 32'h0);

        // CPU requests while booting are ignored
        drive(3'b110, 3'b000, 4'hF, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk($sformatf("boot%0d gnt", i), 32'(bus.m_gnt), 32'h0);
            chk($sformatf("boot%0d ram_req", i), 32'(ram_req), 32'h0);
            chk($sformatf("boot%0d cpu_rst", i), 32'(cpu_rst), 32'h1);
            chk($sformatf("boot%0d rvalid", i), 32'(bus.m_rvalid), 32'h0);
        end

        pv = mk(3'b000, 3'b000, 4'h0, 32'h0, 32'h0, 0, 3'b000, 0, 12'h0, 1, 3'b000, 1, 32'h0);
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            #1;
            drive(vecs[k].req, vecs[k].we, vecs[k].be, vecs[k].addr, vecs[k].wdata);
            boot_done = vecs[k].bd;
            @(negedge clk);
            chk($sformatf("v%0d gnt", k), 32'(bus.m_gnt), 32'(vecs[k].e_gnt));
            chk($sformatf("v%0d ram_req", k), 32'(ram_req), 32'(vecs[k].e_ram_req));
            chk($sformatf("v%0d cpu_rst", k), 32'(cpu_rst), 32'(vecs[k].e_cpu_rst));
            if (vecs[k].e_ram_req) begin
                chk($sformatf("v%0d ram_addr", k), 32'(ram_addr), 32'(vecs[k].e_ram_addr));
                chk($sformatf("v%0d ram_we", k), 32'(ram_we), 32'(vecs[k].we != 3'b000));
                chk($sformatf("v%0d ram_be", k), 32'(ram_be), 32'(vecs[k].be));
                chk($sformatf("v%0d ram_wdata", k), ram_wdata, vecs[k].wdata);
            end else begin
                chk($sformatf("v%0d ram_idle", k), {15'h0, ram_we, ram_be, ram_addr}, 32'h0);
                chk($sformatf("v%0d ram_idle_wdata", k), ram_wdata, 32'h0);
            end
            chk($sformatf("v%0d rvalid(prev)", k), 32'(bus.m_rvalid), 32'(pv.e_rv));
            chk($sformatf("v%0d err(prev)", k), 32'(bus.m_err), 32'(pv.e_err));
            if (pv.chk_rdata)
                chk($sformatf("v%0d rdata(prev)", k), bus.m_rdata, pv.e_rdata);
            pv = vecs[k];
        end

        // Reset while a response for 0x4 is outstanding
        @(posedge clk);
        #1;
        boot_done = 1'b0;
        drive(3'b100, 3'b000, 4'hF, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst seq gnt a0", 32'(bus.m_gnt), 32'h4);
        chk("rst seq ram_addr a0", 32'(ram_addr), 32'h0);
        @(posedge clk);
        #1;
        drive(3'b100, 3'b000, 4'hF, 32'h4, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst seq rvalid a0", 32'(bus.m_rvalid), 32'h4);
        chk("rst seq rdata a0", bus.m_rdata, 32'hA500_0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(3'b100, 3'b000, 4'hF, 32'h8, 32'h0);
        @(negedge clk);
        chk("rst seq rvalid a4 dropped", 32'(bus.m_rvalid), 32'h0);
        chk("rst seq cpu_rst", 32'(cpu_rst), 32'h1);
        chk("rst seq gnt in boot", 32'(bus.m_gnt), 32'h0);
        chk("rst seq ram_req in boot", 32'(ram_req), 32'h0);
        @(posedge clk);
        #1;
        drive(3'b000, 3'b000, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst seq rvalid idle", 32'(bus.m_rvalid), 32'h0);
        chk("rst seq rdata idle", bus.m_rdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arb.md
# ram_port_arb

Single-cycle arbiter and boot sequencer that shares one port of the instruction/data SRAM between three requesters: boot loader (0), CPU instruction fetch (1) and CPU data (2). It owns the boot-to-run handover and holds the CPU in reset until the boot loader signals completion. It performs address range checking, grants at most one request per cycle, and routes the 1-cycle-latency read data back to the granted requester.

## Interface
- DEPTH, 4096: RAM depth in 32-bit words, power of two; AW = $clog2(DEPTH)
- BASE_ADDR, 32'h0000_0000: byte base address of the RAM; aligned to DEPTH*4
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- boot_done  in  1  single-cycle pulse from boot loader: image loaded
- cpu_rst  out  1  active-high reset to CPU core; high in BOOT state
- m_req  in  3  request per requester, bit i = requester i
- m_we  in  3  write enable per requester
- m_be  in  12  byte enables, [4i+3:4i] for requester i
- m_addr  in  96  byte address, [32i+31:32i]
- m_wdata  in  96  write data, [32i+31:32i]
- m_gnt  out  3  grant, combinational, same cycle as accepted req
- m_rvalid  out  3  response valid, one cycle after grant
- m_err  out  3  error, qualified by m_rvalid
- m_rdata  out  32  read data shared by all requesters, qualified by m_rvalid
- ram_req  out  1  RAM access enable
- ram_we  out  1  RAM write enable
- ram_be  out  4  RAM byte enables
- ram_addr  out  AW  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid one cycle after ram_req

## Operation
- FSM states: BOOT, RUN. Reset -> BOOT. BOOT -> RUN on boot_done=1. RUN is terminal until rst.
- cpu_rst = 1 in BOOT, 0 in RUN (registered from state).
- BOOT: only requester 0 eligible; m_req[2:1] ignored (no gnt, no rvalid).
- RUN: requesters 1 and 2 eligible. Requester 0 request is granted and answered with m_err=1, no RAM access.
- Arbitration in RUN between 1 and 2: see Configuration. Exactly one m_gnt bit high per cycle at most; m_gnt = 0 when no eligible req.
- Range check: in range iff m_addr[31:AW+2] == BASE_ADDR[31:AW+2]. Granted in-range request drives ram_req=1, ram_we, ram_be, ram_addr = m_addr[AW+1:2], ram_wdata from winner. addr[1:0] ignored.
- Granted out-of-range request: ram_req=0, response m_err=1, m_rdata=0.
- Response register holds granted index and error flag; next cycle asserts m_rvalid[idx]=1, m_err[idx]=flag, m_rdata = ram_rdata (reads and writes; write rdata is don't-care but driven).
- ram_* outputs are 0 when ram_req=0.

## Timing
- Reset values: state=BOOT, cpu_rst=1, m_rvalid=0, m_err=0, m_rdata=0 (m_rdata is combinational from ram_rdata and is 0 whenever no rvalid), round-robin pointer = requester 1 preferred.
- Grant latency 0 cycles; response latency exactly 1 cycle; fully pipelined, one access per cycle sustained.
- boot_done pulse in same cycle as a requester-0 grant: grant is served as BOOT (RAM access), response delivered next cycle normally; state is RUN from next cycle.
- boot_done in RUN: ignored.
- rst during an outstanding response: response is dropped (m_rvalid=0 next cycle).
- Requests are not queued; a non-granted requester must hold req until m_gnt.

## Configuration
- RAM_ARB_RR_EN defined: round-robin between requesters 1 and 2; after a grant to i the other requester has priority next cycle. Pointer only updates on a grant to 1 or 2.
- Undefined: fixed priority, data (2) over instruction (1); no pointer register.

## Test plan
- Reset, m_req=3'b110 in BOOT -> m_gnt=0, cpu_rst=1, ram_req=0 for 10 cycles.
- BOOT: requester 0 writes 32'hDEAD_BEEF, be=4'hF to addr 0x10, then reads 0x10 -> m_rvalid[0] 1 cycle after each gnt, read returns 32'hDEAD_BEEF, ram_addr=4.
- boot_done pulse -> cpu_rst=0 next cycle; requester 0 read then -> gnt, m_rvalid[0]=1, m_err[0]=1, ram_req=0.
- RUN, m_req=3'b110 held 4 cycles: with RAM_ARB_RR_EN grants 1,2,1,2; without it grants 2,2,2,2.
- Requester 1 reads addr BASE_ADDR+DEPTH*4 -> m_gnt[1]=1, ram_req=0, next cycle m_rvalid[1]=1, m_err[1]=1, m_rdata=0.
- Back-to-back reads from requester 2 to 0x0,0x4,0x8 with rst asserted in cycle 2 -> response for 0x4 suppressed, state BOOT, cpu_rst=1.
